// File: rtl/pipelined_adder.sv
`default_nettype none
// =============================================================================
// pipelined_adder : chunked ripple-carry add/sub, one register stage per chunk
// Revision        : 1.0
// =============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  logic              w_v_last;
  logic [STAGES-1:0] r_vp;

  // Subtraction is a + ~b + ~cin, so borrow-in maps onto carry-in inversion.
  assign w_b_eff   = sub ? ~b : b;
  assign w_c0      = cin ^ sub;
  assign out_valid = r_vp[STAGES-1];

  if (STAGES == 1) begin : g_vp_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vp <= '0;
      else     r_vp <= in_valid;
    end
    assign w_v_last = in_valid;
  end else begin : g_vp_many
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vp <= '0;
      else     r_vp <= {r_vp[STAGES-2:0], in_valid};
    end
    assign w_v_last = r_vp[STAGES-2];
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic             w_ci;
    logic [CHUNK:0]   w_add;
    logic             r_co;
    logic [CHUNK-1:0] r_s_out;

    if (j == 0) begin : g_op_direct
      assign w_a  = a[CHUNK-1:0];
      assign w_b  = w_b_eff[CHUNK-1:0];
      assign w_ci = w_c0;
    end else begin : g_op_skew
      // Chunk j waits j cycles so it meets the carry of the same operation.
      logic [CHUNK-1:0] r_a_d [j];
      logic [CHUNK-1:0] r_b_d [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < j; i++) begin
            r_a_d[i] <= '0;
            r_b_d[i] <= '0;
          end
        end else begin
          r_a_d[0] <= a[j*CHUNK +: CHUNK];
          r_b_d[0] <= w_b_eff[j*CHUNK +: CHUNK];
          for (int i = 1; i < j; i++) begin
            r_a_d[i] <= r_a_d[i-1];
            r_b_d[i] <= r_b_d[i-1];
          end
        end
      end
      assign w_a  = r_a_d[j-1];
      assign w_b  = r_b_d[j-1];
      assign w_ci = g_chunk[j-1].r_co;
    end

    assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, w_ci};
    assign sum[j*CHUNK +: CHUNK] = r_s_out;

    if (j == STAGES - 1) begin : g_top
      logic r_ovf;
      // Output stage only loads on a valid result, so bubbles leave it intact.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s_out <= '0;
          r_co    <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (w_v_last) begin
          r_s_out <= w_add[CHUNK-1:0];
          r_co    <= w_add[CHUNK];
          r_ovf   <= (w_a[CHUNK-1] == w_b[CHUNK-1]) && (w_add[CHUNK-1] != w_a[CHUNK-1]);
        end
      end
      assign carry    = r_co;
      assign overflow = r_ovf;
    end else begin : g_mid
      logic [CHUNK-1:0] r_s_d [STAGES-1-j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_co <= 1'b0;
          for (int i = 0; i < STAGES-1-j; i++) r_s_d[i] <= '0;
        end else begin
          r_co     <= w_add[CHUNK];
          r_s_d[0] <= w_add[CHUNK-1:0];
          for (int i = 1; i < STAGES-1-j; i++) r_s_d[i] <= r_s_d[i-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_s_out <= '0;
        else if (w_v_last) r_s_out <= r_s_d[STAGES-2-j];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// Scoreboard bench: 16/4 directed vectors plus 8/1 and 32/8 random streams.
module tb_pipelined_adder;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        v16, ci16, sb16, ov16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        v8, ci8, sb8, ov8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        v32, ci32, sb32, ov32, co32, of32;
  logic [31:0] a32, b32, s32;

  exp_t q16[$];
  exp_t q8[$];
  exp_t q32[$];
  exp_t last16;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .sum(s16), .carry(co16), .overflow(of16));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(ci8), .sub(sb8),
    .out_valid(ov8), .sum(s8), .carry(co8), .overflow(of8));

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .cin(ci32), .sub(sb32),
    .out_valid(ov32), .sum(s32), .carry(co32), .overflow(of32));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function void spurious(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got out_valid=1 expected 0 (no result outstanding)", nm);
  endfunction

  // Signed/unsigned integer reference, independent of the a + ~b + ~cin form.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c, logic s);
    exp_t   e;
    longint m, ua, ub, sa, sb, ci, r, sr;
    m  = longint'(1) << w;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      r   = ua + ub + ci;
      sr  = sa + sb + ci;
      e.c = (r >= m);
    end else begin
      r   = ua - ub - ci;
      sr  = sa - sb - ci;
      e.c = (r >= 0);
    end
    e.s   = 32'(r & (m - 1));
    e.o   = (sr < -(m / 2)) || (sr >= m / 2);
    e.due = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) last16 = '{s: 32'd0, c: 1'b0, o: 1'b0, due: 0};
    if (ov16) begin
      if (q16.size() == 0) spurious("valid16");
      else begin
        e = q16.pop_front();
        chk("sum16", 32'(s16), e.s);
        chk("carry16", 32'(co16), 32'(e.c));
        chk("ovf16", 32'(of16), 32'(e.o));
        chk("latency16", cyc, e.due);
        last16 = e;
      end
    end else begin
      chk("hold_sum16", 32'(s16), last16.s);
      chk("hold_carry16", 32'(co16), 32'(last16.c));
      chk("hold_ovf16", 32'(of16), 32'(last16.o));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8) begin
      if (q8.size() == 0) spurious("valid8");
      else begin
        e = q8.pop_front();
        chk("sum8", 32'(s8), e.s);
        chk("carry8", 32'(co8), 32'(e.c));
        chk("ovf8", 32'(of8), 32'(e.o));
        chk("latency8", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov32) begin
      if (q32.size() == 0) spurious("valid32");
      else begin
        e = q32.pop_front();
        chk("sum32", s32, e.s);
        chk("carry32", 32'(co32), 32'(e.c));
        chk("ovf32", 32'(of32), 32'(e.o));
        chk("latency32", cyc, e.due);
      end
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic s, input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    @(posedge clk); #1;
    v16 = 1'b1; a16 = a; b16 = b; ci16 = ci; sb16 = s;
    e.s = 32'(es); e.c = ec; e.o = eo; e.due = cyc + 4;
    q16.push_back(e);
  endtask

  task automatic bubble16(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      ci16 = 1'($urandom); sb16 = 1'($urandom);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    v16 = 0; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0;
    v8  = 0; a8  = 0; b8  = 0; ci8  = 0; sb8  = 0;
    v32 = 0; a32 = 0; b32 = 0; ci32 = 0; sb32 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid16", 32'(ov16), 32'd0);
    chk("reset_valid8", 32'(ov8), 32'd0);
    chk("reset_valid32", 32'(ov32), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // basic add, full ripple, signed overflow, subtract with borrow
    issue16(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue16(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    issue16(16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    issue16(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    bubble16(6);

    // back-to-back with one bubble; the hold check covers the gap cycle
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    issue16(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
    issue16(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    bubble16(1);
    issue16(16'h9000, 16'h9000, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b1);
    bubble16(7);

    // asynchronous reset with three operations in flight
    issue16(16'h0101, 16'h0101, 1'b0, 1'b0, 16'h0202, 1'b0, 1'b0);
    issue16(16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h0E0E, 1'b1, 1'b0);
    issue16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    #2 rst = 1'b1;
    q16.delete();
    v16 = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov16), 32'd0);
    chk("async_rst_sum", 32'(s16), 32'd0);
    chk("async_rst_carry", 32'(co16), 32'd0);
    chk("async_rst_ovf", 32'(of16), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bubble16(8);
    issue16(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    bubble16(6);

    // parameter sweep against the integer model
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      v8  = ($urandom_range(0, 4) != 0);
      a8  = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sb8 = 1'($urandom);
      if (v8) begin
        e = model(8, 32'(a8), 32'(b8), ci8, sb8);
        e.due = cyc + 1;
        q8.push_back(e);
      end
      v32 = ($urandom_range(0, 4) != 0);
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); sb32 = 1'($urandom);
      if (v32) begin
        e = model(32, a32, b32, ci32, sb32);
        e.due = cyc + 8;
        q32.push_back(e);
      end
    end
    @(posedge clk); #1;
    v8 = 1'b0; v32 = 1'b0;

    for (int i = 0; i < 40 && (q16.size() + q8.size() + q32.size()) != 0; i++)
      @(posedge clk);
    @(negedge clk);
    chk("drain16", 32'(q16.size()), 32'd0);
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain32", 32'(q32.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 4-bit full adder.
- Operand width is split into STAGES equal chunks, with one register stage per chunk and the carry registered between chunks.
- Accepts one operation per clock, fixed latency of STAGES cycles, valid-qualified.
- Sits in datapaths needing wide add/sub at high clock rate; also a reusable arithmetic primitive for later ALU work.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES must be 0 (elaboration error otherwise); CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on a, b, cin, sub are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  sum/carry/overflow carry a new result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry-out; in sub mode 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub, so sub computes a + ~b + ~cin = a - b - cin.
- Stage k (0..STAGES-1):
  - adds chunk k of a and b_eff plus the carry registered from stage k-1 (c0 for k=0);
  - registers the chunk sum and carry-out.
- Operand skew:
  - upper chunks are delayed k cycles before entering stage k;
  - lower result chunks are delayed so all chunks of one operation exit together.
- Latency: exactly STAGES cycles from an in_valid sample to out_valid. With STAGES=1 this is one register, fully combinational add.
- Throughput: one operation per cycle, no backpressure; in_valid=0 inserts a bubble that propagates unchanged.
- out_valid = in_valid delayed by STAGES cycles.
- Output update rule:
  - sum/carry/overflow update only on cycles where out_valid=1;
  - otherwise they hold the last result.
- Result flags:
  - carry = carry-out of the top chunk.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]); the MSBs travel with the top chunk.
- Operands of a bubble are don't-care and must not disturb held outputs.
- Reset (async, any time):
  - all valid pipeline bits, out_valid, sum, carry and overflow go to 0 immediately;
  - in-flight operations are discarded, never emitted;
  - data pipeline registers may be reset or left; only valid bits and outputs are mandatory.
- After rst deasserts, the first out_valid occurs exactly STAGES cycles after the first sampled in_valid=1.
- No X propagation to outputs while out_valid=0 after reset.

Test Plan:
(WIDTH=16, STAGES=4 unless stated)
1. Latency/basic add: a=0x00FF, b=0x0001, cin=0, sub=0 → 4 cycles later out_valid=1, sum=0x0100, carry=0, overflow=0.
2. Full carry ripple across all stages: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, carry=1, overflow=0; then a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, carry=0, overflow=1.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, carry=0, overflow=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, carry=1, overflow=1.
   - a=0x0010, b=0x0003, sub=1, cin=1 → sum=0x000C, carry=1.
4. Back-to-back with bubble: issue ops on cycles 0,1,2, bubble on 3, op on 4 → out_valid=1 on cycles 4,5,6,8, 0 on 7; results in order; outputs hold cycle-6 value during cycle 7.
5. Reset mid-flight: issue 3 ops on cycles 0–2, assert rst asynchronously mid cycle 2 → out_valid, sum, carry, overflow = 0 at once, no result ever emitted; after release, a new op yields out_valid exactly 4 cycles later.
6. Parameter sweep: WIDTH=8/STAGES=1 (latency 1), WIDTH=32/STAGES=8 (latency 8), with random a/b/cin/sub streams checked against a behavioural (WIDTH+1)-bit model.
